// File: rtl/cruce_pkg.sv
// Shared definitions for the vehicular crossing:
// vehicle light codes and the pedestrian channel state.
package cruce_pkg;

    localparam logic [1:0] LUZ_ROJA     = 2'b00;
    localparam logic [1:0] LUZ_AMARILLA = 2'b01;
    localparam logic [1:0] LUZ_VERDE    = 2'b10;

    typedef enum logic [1:0] {
        PED_IDLE,
        PED_WAIT,
        PED_WALK,
        PED_FLASH
    } ped_state_t;

    // Only 00 counts as red; 11 is treated as non-red.
    function automatic logic is_red(input logic [1:0] luz);
        return luz == LUZ_ROJA;
    endfunction

endpackage

// File: rtl/ped_channel.sv
// One crosswalk: request latch, walk/flash timing, abort on non-red.
// Ports: clk, reset (sync, active-high), enb; light (2b), ped_req;
// outputs walk, flash, pending, hold_red, conflict (1-cycle pulse).
module ped_channel
    import cruce_pkg::*;
#(
    parameter int WALK_CYCLES  = 8,
    parameter int FLASH_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enb,
    input  logic [1:0] light,
    input  logic       ped_req,
    output logic       walk,
    output logic       flash,
    output logic       pending,
    output logic       hold_red,
    output logic       conflict
);

    localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_CYCLES - 1);

    ped_state_t       state, state_n;
    logic [CNT_W-1:0] timer, timer_n;
    logic             again, again_n;
    logic             conflict_n;
    logic             red;
    logic             again_eff;

    assign red = is_red(light);
    // A press on the expiry cycle of FLASH still counts as a re-request.
    assign again_eff = again | ped_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= PED_IDLE;
            timer    <= '0;
            again    <= 1'b0;
            conflict <= 1'b0;
        end else if (enb) begin
            state    <= state_n;
            timer    <= timer_n;
            again    <= again_n;
            conflict <= conflict_n;
        end
    end

    always_comb begin
        state_n    = state;
        timer_n    = timer;
        again_n    = again;
        conflict_n = 1'b0;
        unique case (state)
            PED_IDLE: begin
                if (ped_req) state_n = PED_WAIT;
            end
            PED_WAIT: begin
                if (red) begin
                    state_n = PED_WALK;
                    timer_n = WALK_LOAD;
                end
            end
            PED_WALK: begin
                if (!red) begin
                    state_n    = PED_WAIT;
                    conflict_n = 1'b1;
                    again_n    = 1'b0;
                end else if (timer == '0) begin
                    state_n = PED_FLASH;
                    timer_n = FLASH_LOAD;
                end else begin
                    timer_n = timer - CNT_W'(1);
                end
            end
            PED_FLASH: begin
                if (!red) begin
                    state_n    = PED_WAIT;
                    conflict_n = 1'b1;
                    again_n    = 1'b0;
                end else if (timer == '0) begin
                    state_n = again_eff ? PED_WAIT : PED_IDLE;
                    again_n = 1'b0;
                end else begin
                    timer_n = timer - CNT_W'(1);
                    if (ped_req) again_n = 1'b1;
                end
            end
            default: state_n = PED_IDLE;
        endcase
    end

    assign walk     = (state == PED_WALK);
    assign flash    = (state == PED_FLASH);
    assign pending  = (state == PED_WAIT);
    assign hold_red = walk | flash;

endmodule

// File: rtl/pedestrian_controller.sv
// Pedestrian signals for N_WAYS crosswalks, one channel per approach.
// Ports: clk, reset, enb, veh_light (2b/way), ped_req; per-way walk,
// flash, pending, hold_red and conflict.
module pedestrian_controller
    import cruce_pkg::*;
#(
    parameter int N_WAYS       = 2,
    parameter int WALK_CYCLES  = 8,
    parameter int FLASH_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enb,
    input  logic [2*N_WAYS-1:0] veh_light,
    input  logic [N_WAYS-1:0]   ped_req,
    output logic [N_WAYS-1:0]   walk,
    output logic [N_WAYS-1:0]   flash,
    output logic [N_WAYS-1:0]   pending,
    output logic [N_WAYS-1:0]   hold_red,
    output logic [N_WAYS-1:0]   conflict
);

    for (genvar i = 0; i < N_WAYS; i++) begin : g_way
        ped_channel #(
            .WALK_CYCLES  (WALK_CYCLES),
            .FLASH_CYCLES (FLASH_CYCLES),
            .CNT_W        (CNT_W)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .enb      (enb),
            .light    (veh_light[2*i +: 2]),
            .ped_req  (ped_req[i]),
            .walk     (walk[i]),
            .flash    (flash[i]),
            .pending  (pending[i]),
            .hold_red (hold_red[i]),
            .conflict (conflict[i])
        );
    end

endmodule

// File: tb/tb_pedestrian_controller.sv
// Bench for pedestrian_controller (4 ways, 8 walk, 4 flash):
// directed scenarios plus random traffic against a cycle model.
module tb_pedestrian_controller;

    localparam int NW = 4;
    localparam int WC = 8;
    localparam int FC = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enb = 1'b1;
    logic [2*NW-1:0] veh_light = '0;
    logic [NW-1:0] ped_req = '0;
    logic [NW-1:0] walk, flash, pending, hold_red, conflict;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    // model: phase 0 idle, 1 waiting, 2 walking, 3 flashing
    int m_ph [NW];
    int m_shown [NW];
    bit m_again [NW];
    bit m_conf [NW];

    int c_pend, c_walk, c_flash, c_hold, c_conf;

    pedestrian_controller #(
        .N_WAYS       (NW),
        .WALK_CYCLES  (WC),
        .FLASH_CYCLES (FC),
        .CNT_W        (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enb       (enb),
        .veh_light (veh_light),
        .ped_req   (ped_req),
        .walk      (walk),
        .flash     (flash),
        .pending   (pending),
        .hold_red  (hold_red),
        .conflict  (conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [NW-1:0] m_vec(input int ph);
        logic [NW-1:0] v;
        for (int i = 0; i < NW; i++) v[i] = (m_ph[i] == ph);
        return v;
    endfunction

    function automatic logic [NW-1:0] m_cvec();
        logic [NW-1:0] v;
        for (int i = 0; i < NW; i++) v[i] = m_conf[i];
        return v;
    endfunction

    task automatic model_step();
        if (reset) begin
            for (int i = 0; i < NW; i++) begin
                m_ph[i] = 0; m_shown[i] = 0;
                m_again[i] = 0; m_conf[i] = 0;
            end
        end else if (enb) begin
            for (int i = 0; i < NW; i++) begin
                bit red;
                red = (veh_light[2*i +: 2] == 2'b00);
                m_conf[i] = 0;
                case (m_ph[i])
                    0: if (ped_req[i]) m_ph[i] = 1;
                    1: if (red) begin m_ph[i] = 2; m_shown[i] = 0; end
                    2: begin
                        if (!red) begin
                            m_ph[i] = 1; m_conf[i] = 1;
                        end else begin
                            m_shown[i]++;
                            if (m_shown[i] == WC) begin
                                m_ph[i] = 3; m_shown[i] = 0;
                            end
                        end
                    end
                    default: begin
                        if (!red) begin
                            m_ph[i] = 1; m_conf[i] = 1; m_again[i] = 0;
                        end else begin
                            m_shown[i]++;
                            if (ped_req[i]) m_again[i] = 1;
                            if (m_shown[i] == FC) begin
                                m_ph[i] = m_again[i] ? 1 : 0;
                                m_again[i] = 0;
                            end
                        end
                    end
                endcase
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("pending", int'(pending), int'(m_vec(1)));
            check("walk", int'(walk), int'(m_vec(2)));
            check("flash", int'(flash), int'(m_vec(3)));
            check("hold_red", int'(hold_red),
                  int'(m_vec(2) | m_vec(3)));
            check("conflict", int'(conflict), int'(m_cvec()));
        end
    end

    // counts way-0 indications over enabled cycles
    task automatic tick();
        if (enb && !reset) begin
            c_pend += int'(pending[0]);
            c_walk += int'(walk[0]);
            c_flash += int'(flash[0]);
            c_hold += int'(hold_red[0]);
            c_conf += int'(conflict[0]);
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic clr();
        c_pend = 0; c_walk = 0; c_flash = 0; c_hold = 0; c_conf = 0;
    endtask

    task automatic pulse0();
        ped_req[0] = 1'b1; tick(); ped_req[0] = 1'b0;
    endtask

    initial begin
        clr();
        model_step();
        chk_on = 1'b1;
        ticks(2);
        reset = 1'b0;
        check("rst_outs", int'({walk, flash, pending, hold_red, conflict}), 0);

        // single crossing on way 0
        clr(); pulse0(); ticks(15);
        check("A_pend", c_pend, 1);
        check("A_walk", c_walk, WC);
        check("A_flash", c_flash, FC);
        check("A_hold", c_hold, WC + FC);
        check("A_idle", int'({walk[0], flash[0], pending[0]}), 0);

        // way 1 green holds the request in pending
        veh_light[3:2] = 2'b10;
        ped_req[1] = 1'b1; tick(); ped_req[1] = 1'b0;
        ticks(5);
        check("B_pend", int'(pending[1]), 1);
        check("B_nowalk", int'(walk[1]), 0);
        veh_light[3:2] = 2'b00; tick();
        check("B_walk", int'(walk[1]), 1);
        ticks(14);

        // abort during walk cycle 4
        clr(); pulse0(); ticks(4);
        check("C_inwalk", int'(walk[0]), 1);
        veh_light[1:0] = 2'b01; tick();
        check("C_abort", int'({walk[0], pending[0], conflict[0]}), 3'b011);
        tick();
        check("C_pulse", int'(conflict[0]), 0);
        clr(); veh_light[1:0] = 2'b00; ticks(16);
        check("C_walk", c_walk, WC);
        check("C_flash", c_flash, FC);
        check("C_idle", int'(hold_red[0] | pending[0]), 0);

        // request during flash rearms; during walk is ignored
        clr(); pulse0(); ticks(10);
        check("D_inflash", int'(flash[0]), 1);
        pulse0(); ticks(20);
        check("D_walk2", c_walk, 2 * WC);
        check("D_flash2", c_flash, 2 * FC);
        check("D_pend2", c_pend, 2);
        clr(); pulse0(); ticks(3);
        pulse0(); ticks(16);
        check("D_walkign", c_walk, WC);
        check("D_idle", int'(pending[0] | hold_red[0]), 0);

        // freeze mid-walk, walk still totals 8 enabled cycles
        clr(); pulse0(); ticks(3);
        enb = 1'b0; ticks(5);
        check("E_frozen", int'(walk[0]), 1);
        enb = 1'b1; ticks(14);
        check("E_walk", c_walk, WC);
        check("E_flash", c_flash, FC);
        pulse0(); ticks(4);
        enb = 1'b0; reset = 1'b1; tick();
        check("E_rst", int'({walk, flash, pending, hold_red, conflict}), 0);
        reset = 1'b0; enb = 1'b1;

        // four ways, 0 and 2 red, 1 and 3 green
        veh_light = 8'b10_00_10_00;
        ped_req = 4'b1111; tick(); ped_req = '0; tick();
        check("F_walk", int'(walk), 4'b0101);
        check("F_pend", int'(pending), 4'b1010);
        ticks(14);

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < NW; i++) begin
                if ($urandom_range(0, 19) == 0)
                    veh_light[2*i +: 2] = ($urandom_range(0, 2) == 0) ?
                        2'($urandom) : 2'b00;
            end
            ped_req = 4'($urandom) & 4'($urandom) & 4'($urandom);
            enb = ($urandom_range(0, 7) != 0);
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0; enb = 1'b1; ped_req = '0;
        tick();
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
